seq_div_8bit: RTL

SEQ_DIV_8BIT -- requirements
Module: seq_div_8bit

---
 rtl/seq_div_8bit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seq_div_8bit.sv
// seq_div_8bit -- sequential unsigned restoring divider.
//
// A start seen while idle (or in the done cycle) captures the operands and
// runs WIDTH shift/subtract iterations, one per clock, then presents the
// registered quotient/remainder with a one-cycle done pulse. A zero divisor
// skips the iterations and completes on the next edge with quotient all ones
// and remainder equal to the dividend.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a division (ignored while busy)
//   dividend     in   [WIDTH-1:0] unsigned dividend, sampled with start
//   divisor      in   [WIDTH-1:0] unsigned divisor, sampled with start
//   quotient     out  [WIDTH-1:0] quotient of the last completed operation
//   remainder    out  [WIDTH-1:0] remainder of the last completed operation
//   busy         out  high while iterating
//   done         out  one-cycle pulse, first cycle the results are valid
//   div_by_zero  out  last completed operation had divisor = 0
module seq_div_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_p_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept = start && (r_state != S_RUN);
  assign w_zero   = (divisor == '0);
  // The counter reaching WIDTH means all iterations have been applied; that
  // extra RUN cycle is the one that transfers P/Q into the result registers.
  assign w_last   = (r_cnt == CW'(WIDTH));

  // One restoring step; the WIDTH+1 bit difference keeps the borrow in the MSB.
  assign w_shift  = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_t      = w_shift - {1'b0, r_d};
  assign w_p_next = w_t[WIDTH] ? w_shift : w_t;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_t[WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = w_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_next = w_zero ? S_DONE : S_RUN;
        else       w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept && !w_zero) begin
        r_p   <= '0;
        r_q   <= dividend;
        r_d   <= divisor;
        r_cnt <= '0;
      end else if (r_state == S_RUN && !w_last) begin
        r_p   <= w_p_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_accept && w_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (r_state == S_RUN && w_last) begin
        quotient    <= r_q;
        remainder   <= r_p[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
